// File: rtl/register_transfer_sequencer.sv
// Expands (source, destination) register-transfer commands into a DRIVE/LOAD/RELEASE
// sequence on the register control bus. Optional command FIFO: define SEQ_CMD_FIFO_EN.
module register_transfer_sequencer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock_in,
  input  logic        reset_n_in,
  input  logic        cmd_valid_in,
  output logic        cmd_ready_out,
  input  logic [2:0]  cmd_src_in,
  input  logic [2:0]  cmd_dst_in,
  output logic [11:0] Register_Control_Bus,
  output logic        ext_drive_out,
  output logic        busy_out,
  output logic        done_out,
  output logic        err_out
);

  typedef enum logic [1:0] {IDLE, DRIVE, LOAD, RELEASE} state_t;

  localparam logic [2:0] SRC_EXT = 3'd6;

  state_t     state;
  logic [2:0] src_q;
  logic [2:0] dst_q;
  logic       accept;
  logic       illegal;
  logic       start;
  logic [2:0] start_src;
  logic [2:0] start_dst;

  assign accept  = cmd_valid_in && cmd_ready_out;
  assign illegal = (cmd_src_in == 3'd7) || (cmd_dst_in[2:1] == 2'b11);

  function automatic logic [11:0] oe_bits(input logic [2:0] s);
    oe_bits = '0;
    if (s < SRC_EXT) oe_bits[4'd6 + {1'b0, s}] = 1'b1;
  endfunction

  function automatic logic [11:0] load_bits(input logic [2:0] d);
    load_bits = '0;
    if (d < 3'd6) load_bits[d] = 1'b1;
  endfunction

`ifdef SEQ_CMD_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [5:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   occupancy;
  logic          staged;
  logic [2:0]    stage_src;
  logic [2:0]    stage_dst;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // The stage register is the FIFO's output slot, so it counts toward occupancy.
  assign occupancy     = count + {{AW{1'b0}}, staged};
  assign full          = (occupancy == (AW + 1)'(FIFO_DEPTH));
  assign empty         = (count == '0);
  assign start         = staged && (state == IDLE);
  assign pop           = !empty && (!staged || start);
  assign cmd_ready_out = !full || start;
  assign push          = accept && !illegal;
  assign start_src     = stage_src;
  assign start_dst     = stage_dst;

  always_ff @(posedge clock_in) begin
    if (push) mem[wr_ptr] <= {cmd_src_in, cmd_dst_in};
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      staged    <= 1'b0;
      stage_src <= '0;
      stage_dst <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        {stage_src, stage_dst} <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
        staged <= 1'b1;
      end else if (start) begin
        staged <= 1'b0;
      end
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
`else
  assign start         = accept && !illegal;
  assign start_src     = cmd_src_in;
  assign start_dst     = cmd_dst_in;
  assign cmd_ready_out = (state == IDLE);
`endif

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state                <= IDLE;
      src_q                <= '0;
      dst_q                <= '0;
      Register_Control_Bus <= '0;
      ext_drive_out        <= 1'b0;
      busy_out             <= 1'b0;
      done_out             <= 1'b0;
      err_out              <= 1'b0;
    end else begin
      done_out <= 1'b0;
      err_out  <= accept && illegal;
      unique case (state)
        IDLE: begin
          if (start) begin
            src_q                <= start_src;
            dst_q                <= start_dst;
            state                <= DRIVE;
            busy_out             <= 1'b1;
            Register_Control_Bus <= oe_bits(start_src);
            ext_drive_out        <= (start_src == SRC_EXT);
          end
        end
        // Source keeps driving while the destination load enable spans the falling edge.
        DRIVE: begin
          state                <= LOAD;
          Register_Control_Bus <= oe_bits(src_q) | load_bits(dst_q);
        end
        LOAD: begin
          state                <= RELEASE;
          Register_Control_Bus <= '0;
          ext_drive_out        <= 1'b0;
          done_out             <= 1'b1;
        end
        RELEASE: begin
          state    <= IDLE;
          busy_out <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/register_transfer_sequencer.md
# register_transfer_sequencer

Control-path stage directly upstream of the register file. It accepts register-transfer commands (source, destination) over a valid/ready handshake and expands each one into a timed sequence on the 12-bit `Register_Control_Bus`. That sequence raises one output-enable bit, overlaps it with one load-enable bit across a falling clock edge, then releases the bus. It also flags when an external agent must drive the shared bus.

## Interface
- `FIFO_DEPTH`, default 4: command FIFO entries, power of 2, at least 2. Used only when `SEQ_CMD_FIFO_EN` is defined.
- `clock_in` input 1: system clock. The sequencer acts on the rising edge.
- `reset_n_in` input 1: reset, asynchronous and active-low.
- `cmd_valid_in` input 1: command present.
- `cmd_ready_out` output 1: command can be accepted.
- `cmd_src_in` input 3: source code. 0=A, 1=B, 2=C, 3=P, 4=S, 5=ST, 6=EXT (external bus driver), 7=illegal.
- `cmd_dst_in` input 3: destination code. 0–5 as for source; 6 and 7 are illegal.
- `Register_Control_Bus` output 12: bits [5:0] are load enables (A,B,C,P,S,ST); bits [11:6] are output enables in the same order.
- `ext_drive_out` output 1: external agent must drive the bus (EXT source only).
- `busy_out` output 1: a transfer is in progress (state ≠ IDLE).
- `done_out` output 1: one-cycle pulse when a transfer completes.
- `err_out` output 1: one-cycle pulse when an illegal command is rejected.

## Operation
- Handshake: a command is accepted on a rising edge where `cmd_valid_in && cmd_ready_out`. Source and destination are captured into internal registers.
- Legality is checked at acceptance:
  - Source 7, destination 6, or destination 7 makes the command illegal.
  - An illegal command is consumed. `err_out`=1 in the next cycle. There is no state change and no bus activity.
- `src==dst` is legal; the register reloads its own value.
- State machine, all outputs registered:
  - IDLE: all control bits 0; `cmd_ready_out`=1 when no FIFO is present. A legal accept moves to DRIVE.
  - DRIVE: `Register_Control_Bus[6+src]`=1, or `ext_drive_out`=1 if src=EXT. Always moves to LOAD.
  - LOAD: the DRIVE output stays asserted and `Register_Control_Bus[dst]`=1. The destination captures on the falling edge within this cycle. Always moves to RELEASE.
  - RELEASE: all 12 bits 0, `ext_drive_out`=0, `done_out`=1. Always moves to IDLE.
- At most one OE bit and one load bit are ever high. OE bits are never high in IDLE or RELEASE, so every transfer presents a fresh OE rising edge.
- Reset, including mid-transfer:
  - State goes to IDLE immediately (asynchronously).
  - `Register_Control_Bus`=0, `ext_drive_out`=0, `busy_out`=0, `done_out`=0, `err_out`=0.
  - Any captured command is discarded and the FIFO is flushed.
  - `cmd_ready_out`=1 as soon as `reset_n_in` is high.

## Timing
- Without the FIFO, for a command accepted at edge N:
  - DRIVE occupies cycle N..N+1.
  - LOAD occupies N+1..N+2.
  - RELEASE (`done_out`) occupies N+2..N+3.
  - IDLE and `cmd_ready_out`=1 resume at N+3.
- Throughput is one transfer per 4 cycles, including the IDLE cycle.
- `err_out` asserts in cycle N..N+1 only; `cmd_ready_out` stays 1.
- The sequencer assumes the register file drives and loads within one cycle; no wait states are inserted.

## Configuration
- `SEQ_CMD_FIFO_EN` defined:
  - Legal commands are written into a `FIFO_DEPTH`-entry FIFO; `cmd_ready_out` = FIFO not full.
  - Illegal commands never enter the FIFO. They are consumed with `err_out` even while the sequencer is busy.
  - In IDLE with the FIFO non-empty, the sequencer pops one entry per edge into DRIVE.
  - Accept-to-DRIVE latency is 2 cycles. Back-to-back queued commands run every 4 cycles.
  - A push and a pop in the same cycle is allowed when the FIFO is full; occupancy is unchanged.
- Not defined:
  - No FIFO; behaviour is exactly as in Timing.
  - `cmd_ready_out` is 1 only in IDLE.

## Test plan
- Reset, then src=0 (A), dst=1 (B) accepted at edge 1.
  - Bus reads 0x040 in cycle 1, 0x042 in cycle 2, 0x000 in cycle 3.
  - `done_out` is 1 in cycle 3; `cmd_ready_out` is 1 at edge 4.
- src=6 (EXT), dst=5 (ST).
  - `ext_drive_out`=1 for 2 cycles; bus reads 0x000 then 0x020.
  - No OE bit is ever set.
- Illegal commands src=7 dst=0, then src=2 dst=6.
  - `err_out` pulses once for each; bus stays 0x000.
  - `busy_out` stays 0.
- Assert `reset_n_in`=0 during LOAD of src=3 dst=4.
  - Bus goes to 0x000 immediately and `done_out` never pulses.
  - After release, a new command proceeds normally.
- With `SEQ_CMD_FIFO_EN` and `FIFO_DEPTH`=4, present 6 back-to-back valid commands.
  - `cmd_ready_out` drops after 4 are queued, while the first is still in flight.
  - All 6 complete in order, with `done_out` pulses spaced 4 cycles apart.
- Assertions on every cycle of a random-command run:
  - At most one OE bit and one load bit are set.
  - OE is 0 in the cycle after each `done_out`.
